// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter for three masters. It applies a per-tenure transfer
// quota, supports HLOCK, and parks the bus on DEF_MASTER when nobody requests.
module ahb_rr_arbiter #(
  parameter int QUOTA      = 4,
  parameter int DEF_MASTER = 0
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [2:0] HBUSREQ,
  input  logic [2:0] HLOCK,
  input  logic [1:0] HTRANS_S,
  input  logic       HREADY_S,
  output logic [2:0] HGRANT,
  output logic [1:0] HMASTER,
  output logic [1:0] HMASTER_D,
  output logic       HMASTLOCK
);

  localparam int            QW        = $clog2(QUOTA + 1);
  localparam logic [QW-1:0] QUOTA_MAX = QW'(QUOTA);
  localparam logic [1:0]    DEF_IDX   = 2'(DEF_MASTER);
  localparam logic [2:0]    DEF_GRANT = 3'b001 << DEF_IDX;
  localparam logic [1:0]    TR_NONSEQ = 2'b10;
  localparam logic [1:0]    TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {PARK, OWN, LOCK} state_t;

  state_t        state, state_nxt;
  logic [2:0]    grant, grant_nxt;
  logic [1:0]    master, master_d, last_owner;
  logic [1:0]    grant_idx, winner, scan0, scan1, scan2;
  logic [QW-1:0] quota_cnt;
  logic          others_req, keep_owner;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  always_comb begin
    unique case (grant)
      3'b010:  grant_idx = 2'd1;
      3'b100:  grant_idx = 2'd2;
      default: grant_idx = 2'd0;
    endcase
  end

  // Rotating scan starts just past the master most recently loaded into HMASTER.
  always_comb begin
    scan0 = next_idx(last_owner);
    scan1 = next_idx(scan0);
    scan2 = next_idx(scan1);
    if (HBUSREQ[scan0])      winner = scan0;
    else if (HBUSREQ[scan1]) winner = scan1;
    else                     winner = scan2;
    others_req = |(HBUSREQ & ~one_hot(grant_idx));
    keep_owner = HBUSREQ[grant_idx] && ((quota_cnt < QUOTA_MAX) || !others_req);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= PARK;
      grant      <= DEF_GRANT;
      master     <= DEF_IDX;
      master_d   <= DEF_IDX;
      quota_cnt  <= '0;
      last_owner <= 2'd2;
    end else if (HREADY_S) begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      master     <= grant_idx;
      master_d   <= master;
      last_owner <= grant_idx;
      if (grant_idx != master)
        quota_cnt <= '0;
      else if (HTRANS_S[1] && (quota_cnt < QUOTA_MAX))
        quota_cnt <= quota_cnt + QW'(1);
    end
  end

  // Starting a locked sequence freezes the grant on that same edge, so a
  // master at its quota cannot lose the bus while it begins a lock.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    if (HREADY_S) begin
      unique case (state)
        LOCK: begin
          if (!HLOCK[master] && (HTRANS_S != TR_SEQ))
            state_nxt = OWN;
        end
        default: begin
          if ((state == OWN) && (HTRANS_S == TR_NONSEQ) && HLOCK[master]) begin
            state_nxt = LOCK;
          end else if (HTRANS_S != TR_SEQ) begin
            if (HBUSREQ == 3'b000) begin
              state_nxt = PARK;
              grant_nxt = DEF_GRANT;
            end else if (keep_owner) begin
              state_nxt = OWN;
            end else begin
              state_nxt = OWN;
              grant_nxt = one_hot(winner);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    HGRANT    = grant;
    HMASTER   = master;
    HMASTER_D = master_d;
    HMASTLOCK = (state == LOCK);
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed scoreboard bench for ahb_rr_arbiter (QUOTA=4, DEF_MASTER=0).
// The driver queues hand-computed per-cycle outputs; the monitor checks them on the falling edge.
module tb_ahb_rr_arbiter;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NS   = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [2:0] HBUSREQ = 3'b000;
  logic [2:0] HLOCK = 3'b000;
  logic [1:0] HTRANS_S = IDLE;
  logic       HREADY_S = 1'b1;
  logic [2:0] HGRANT;
  logic [1:0] HMASTER;
  logic [1:0] HMASTER_D;
  logic       HMASTLOCK;

  typedef struct packed {
    logic [7:0] vec;
    logic [2:0] grant;
    logic [1:0] master;
    logic [1:0] master_d;
    logic       mastlock;
  } expect_t;

  expect_t exp_q[$];
  expect_t mon_e;
  int      checks = 0;
  int      passes = 0;
  int      vec_num = 0;

  ahb_rr_arbiter #(.QUOTA(4), .DEF_MASTER(0)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .HBUSREQ(HBUSREQ),
    .HLOCK(HLOCK),
    .HTRANS_S(HTRANS_S),
    .HREADY_S(HREADY_S),
    .HGRANT(HGRANT),
    .HMASTER(HMASTER),
    .HMASTER_D(HMASTER_D),
    .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  // Inputs for one cycle plus the outputs expected during that same cycle.
  task automatic applyStimulus(input logic rst_n, input logic [2:0] req, input logic [2:0] lock,
                               input logic [1:0] trans, input logic ready,
                               input logic [1:0] exp_owner, input logic [1:0] exp_master,
                               input logic [1:0] exp_master_d, input logic exp_lock);
    expect_t e;
    @(posedge HCLK);
    #1;
    HRESETn  = rst_n;
    HBUSREQ  = req;
    HLOCK    = lock;
    HTRANS_S = trans;
    HREADY_S = ready;
    e.vec      = 8'(vec_num);
    e.grant    = 3'b001 << exp_owner;
    e.master   = exp_master;
    e.master_d = exp_master_d;
    e.mastlock = exp_lock;
    exp_q.push_back(e);
    vec_num++;
  endtask

  task automatic checkOutput(input string name, input int vec, input logic [2:0] actual,
                             input logic [2:0] expected);
    checks++;
    if (actual === expected)
      passes++;
    else
      $display("[TB] FAIL %s vec %0d: got %0h, expected %0h", name, vec, actual, expected);
  endtask

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("HGRANT", int'(mon_e.vec), HGRANT, mon_e.grant);
      checkOutput("HMASTER", int'(mon_e.vec), {1'b0, HMASTER}, {1'b0, mon_e.master});
      checkOutput("HMASTER_D", int'(mon_e.vec), {1'b0, HMASTER_D}, {1'b0, mon_e.master_d});
      checkOutput("HMASTLOCK", int'(mon_e.vec), {2'b00, HMASTLOCK}, {2'b00, mon_e.mastlock});
      checkOutput("grant_onehot", int'(mon_e.vec), {2'b00, $onehot(HGRANT)}, 3'b001);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held, then released with no requests: outputs stay parked on M0.
    applyStimulus(0, 3'b000, 3'b000, IDLE, 1, 0, 0, 0, 0);
    applyStimulus(0, 3'b000, 3'b000, IDLE, 1, 0, 0, 0, 0);
    applyStimulus(1, 3'b000, 3'b000, IDLE, 1, 0, 0, 0, 0);
    applyStimulus(1, 3'b000, 3'b000, IDLE, 1, 0, 0, 0, 0);

    // Fairness: all request, NONSEQ every cycle; ownership rotates M0 -> M1 -> M2 -> M0.
    for (int i = 0; i < 5; i++) applyStimulus(1, 3'b111, 3'b000, NS, 1, 0, 0, 0, 0);
    applyStimulus(1, 3'b111, 3'b000, NS, 1, 1, 0, 0, 0);
    applyStimulus(1, 3'b111, 3'b000, NS, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 3'b111, 3'b000, NS, 1, 1, 1, 1, 0);
    applyStimulus(1, 3'b111, 3'b000, NS, 1, 2, 1, 1, 0);
    applyStimulus(1, 3'b111, 3'b000, NS, 1, 2, 2, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 3'b111, 3'b000, NS, 1, 2, 2, 2, 0);
    applyStimulus(1, 3'b111, 3'b000, NS, 1, 0, 2, 2, 0);
    applyStimulus(1, 3'b111, 3'b000, NS, 1, 0, 0, 2, 0);

    // Burst protection: M1 at quota with M2 pending, SEQ beats hold the grant.
    applyStimulus(1, 3'b010, 3'b000, NS, 1, 0, 0, 0, 0);
    applyStimulus(1, 3'b010, 3'b000, NS, 1, 1, 0, 0, 0);
    applyStimulus(1, 3'b010, 3'b000, NS, 1, 1, 1, 0, 0);
    applyStimulus(1, 3'b010, 3'b000, NS, 1, 1, 1, 1, 0);
    applyStimulus(1, 3'b010, 3'b000, NS, 1, 1, 1, 1, 0);
    applyStimulus(1, 3'b110, 3'b000, NS, 1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 3'b110, 3'b000, SEQ, 1, 1, 1, 1, 0);
    applyStimulus(1, 3'b110, 3'b000, IDLE, 1, 1, 1, 1, 0);
    applyStimulus(1, 3'b110, 3'b000, IDLE, 1, 2, 1, 1, 0);

    // Lock: M2 locks while M0/M1 request; grant frozen beyond quota until unlock + IDLE.
    applyStimulus(1, 3'b111, 3'b100, NS, 1, 2, 2, 1, 0);
    applyStimulus(1, 3'b111, 3'b100, SEQ, 1, 2, 2, 2, 1);
    applyStimulus(1, 3'b111, 3'b100, SEQ, 1, 2, 2, 2, 1);
    applyStimulus(1, 3'b111, 3'b100, NS, 1, 2, 2, 2, 1);
    applyStimulus(1, 3'b111, 3'b100, SEQ, 1, 2, 2, 2, 1);
    applyStimulus(1, 3'b111, 3'b100, NS, 1, 2, 2, 2, 1);
    applyStimulus(1, 3'b111, 3'b000, IDLE, 1, 2, 2, 2, 1);
    applyStimulus(1, 3'b111, 3'b000, IDLE, 1, 2, 2, 2, 0);
    applyStimulus(1, 3'b111, 3'b000, IDLE, 1, 0, 2, 2, 0);

    // Wait states during the M0 -> M1 handover.
    applyStimulus(1, 3'b010, 3'b000, IDLE, 1, 0, 0, 2, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 3'b010, 3'b000, IDLE, 0, 1, 0, 0, 0);
    applyStimulus(1, 3'b010, 3'b000, IDLE, 1, 1, 0, 0, 0);
    applyStimulus(1, 3'b010, 3'b000, NS, 1, 1, 1, 0, 0);
    applyStimulus(1, 3'b010, 3'b000, NS, 1, 1, 1, 1, 0);

    // Park: all requests drop while M1 owns.
    applyStimulus(1, 3'b000, 3'b000, IDLE, 1, 1, 1, 1, 0);
    applyStimulus(1, 3'b000, 3'b000, IDLE, 1, 0, 1, 1, 0);
    applyStimulus(1, 3'b000, 3'b000, IDLE, 1, 0, 0, 1, 0);
    applyStimulus(1, 3'b000, 3'b000, IDLE, 1, 0, 0, 0, 0);

    // Asynchronous reset asserted mid-transfer.
    applyStimulus(1, 3'b111, 3'b000, NS, 1, 0, 0, 0, 0);
    applyStimulus(1, 3'b010, 3'b000, NS, 1, 0, 0, 0, 0);
    applyStimulus(1, 3'b010, 3'b000, NS, 1, 1, 0, 0, 0);
    applyStimulus(0, 3'b010, 3'b000, NS, 1, 0, 0, 0, 0);
    applyStimulus(1, 3'b000, 3'b000, IDLE, 1, 0, 0, 0, 0);

    repeat (3) @(posedge HCLK);
    checks++;
    if (exp_q.size() == 0)
      passes++;
    else
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
